// File: rtl/weight_stream_reader.sv
// weight_stream_reader: streams DEPTH words from a one-port falling-edge BRAM to a valid/ready MAC port
module weight_stream_reader #(
   parameter int DEPTH  = 28,
   parameter int ADDR_W = 5,
   parameter int DATA_W = 16
) (
   input  logic              CLK,
   input  logic              RST_N,
   input  logic              START,
   output logic              BUSY,
   output logic              DONE,
   output logic [ADDR_W-1:0] MEM_ADDR,
   output logic              MEM_EN,
   output logic              MEM_WE,
   output logic [DATA_W-1:0] MEM_DI,
   input  logic [DATA_W-1:0] MEM_DO,
   output logic [DATA_W-1:0] W_DATA,
   output logic              W_VALID,
   input  logic              W_READY,
   output logic              W_LAST
);
   typedef enum logic [1:0] {IDLE, FETCH, DRAIN, DONE_ST} state_t;
   localparam logic [ADDR_W:0]   IDX_DEPTH = (ADDR_W+1)'(DEPTH);
   localparam logic [ADDR_W:0]   IDX_LAST  = (ADDR_W+1)'(DEPTH - 1);
   localparam logic [ADDR_W-1:0] ADDR_LAST = ADDR_W'(DEPTH - 1);
   state_t            state_q, state_d;
   logic [ADDR_W:0]   idx_q, idx_d;
   logic [ADDR_W-1:0] addr_q, addr_d;
   logic              en_q, en_d, infl_q, infl_d;
   logic [DATA_W-1:0] dat0_q, dat0_d, dat1_q, dat1_d;
   logic              last0_q, last0_d, last1_q, last1_d;
   logic [1:0]        cnt_q, cnt_d;
   logic              pop, issue;
   logic [2:0]        occ;
   always_comb begin
      pop     = (cnt_q != 2'd0) && W_READY;
      // occupancy the buffer will see once the word already in flight lands
      occ     = {1'b0, cnt_q} + {2'b0, infl_q} - {2'b0, pop};
      issue   = (state_q == FETCH) && (idx_q < IDX_DEPTH) && (occ < 3'd2);
      state_d = state_q;
      idx_d   = idx_q;
      addr_d  = issue ? idx_q[ADDR_W-1:0] : addr_q;
      en_d    = issue;
      infl_d  = issue;
      case (state_q)
         IDLE: begin
            state_d = START ? FETCH : IDLE;
            idx_d   = START ? '0 : idx_q;
         end
         FETCH: begin
            idx_d   = issue ? idx_q + (ADDR_W+1)'(1) : idx_q;
            state_d = (issue && idx_q == IDX_LAST) ? DRAIN : FETCH;
         end
         DRAIN:   state_d = (pop && last0_q) ? DONE_ST : DRAIN;
         DONE_ST: state_d = IDLE;
      endcase
      dat0_d  = pop ? dat1_q : dat0_q;
      last0_d = pop ? last1_q : last0_q;
      dat1_d  = dat1_q;
      last1_d = last1_q;
      cnt_d   = cnt_q - {1'b0, pop};
      if (infl_q) begin
         if (cnt_d == 2'd0) begin
            dat0_d  = MEM_DO;
            last0_d = addr_q == ADDR_LAST;
         end else begin
            dat1_d  = MEM_DO;
            last1_d = addr_q == ADDR_LAST;
         end
         cnt_d = cnt_d + 2'd1;
      end
   end
   always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N) begin
         state_q <= IDLE;
         idx_q   <= '0;
         addr_q  <= '0;
         en_q    <= 1'b0;
         infl_q  <= 1'b0;
         dat0_q  <= '0;
         dat1_q  <= '0;
         last0_q <= 1'b0;
         last1_q <= 1'b0;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         idx_q   <= idx_d;
         addr_q  <= addr_d;
         en_q    <= en_d;
         infl_q  <= infl_d;
         dat0_q  <= dat0_d;
         dat1_q  <= dat1_d;
         last0_q <= last0_d;
         last1_q <= last1_d;
         cnt_q   <= cnt_d;
      end
   end
   assign BUSY     = (state_q == FETCH) || (state_q == DRAIN);
   assign DONE     = state_q == DONE_ST;
   assign MEM_ADDR = addr_q;
   assign MEM_EN   = en_q;
   assign MEM_WE   = 1'b0;
   assign MEM_DI   = '0;
   assign W_DATA   = dat0_q;
   assign W_VALID  = cnt_q != 2'd0;
   assign W_LAST   = last0_q;
endmodule
